// File: rtl/bist_controller_if.sv
// Control/status bundle between the BIST sequencer and the TPG/MISR datapath and chip pins.
// With BIST_SIG_EXPORT_EN defined the bundle also carries the captured signature sig_snap.
interface bist_controller_if #(
    parameter int SIG_W = 49
);
    logic             bistmode;
    logic [SIG_W-1:0] misr_sig;
    logic             tpg_load;
    logic             tpg_en;
    logic             misr_clear;
    logic             misr_en;
    logic             test_mode;
    logic             bistdone;
    logic             bistpass;
`ifdef BIST_SIG_EXPORT_EN
    logic [SIG_W-1:0] sig_snap;
`endif

    modport master (
        input  bistmode,
        input  misr_sig,
        output tpg_load,
        output tpg_en,
        output misr_clear,
        output misr_en,
        output test_mode,
        output bistdone,
        output bistpass
`ifdef BIST_SIG_EXPORT_EN
        , output sig_snap
`endif
    );

    modport slave (
        output bistmode,
        output misr_sig,
        input  tpg_load,
        input  tpg_en,
        input  misr_clear,
        input  misr_en,
        input  test_mode,
        input  bistdone,
        input  bistpass
`ifdef BIST_SIG_EXPORT_EN
        , input sig_snap
`endif
    );
endinterface

// File: rtl/bist_controller.sv
// BIST sequencer: seeds/steps the TPG, gates the MISR across CUT latency, compares the signature.
// Optional feature macro: BIST_SIG_EXPORT_EN (adds the sig_snap signature capture register).
module bist_controller #(
    parameter int               NUM_PATTERNS = 1024,
    parameter int               CUT_LAT      = 1,
    parameter int               SIG_W        = 49,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = {SIG_W{1'b0}}
) (
    input logic         clk,
    input logic         rst,
    bist_controller_if.master bus
);

    localparam int              CNT_W      = $clog2(NUM_PATTERNS + 1);
    localparam int              LAT_LAST_I = (CUT_LAT > 32'sd0) ? (CUT_LAT - 32'sd1) : 32'sd0;
    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(NUM_PATTERNS - 32'sd1);
    localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(CUT_LAT);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LAT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'sd1);
    localparam logic            LAT_ZERO   = (CUT_LAT == 32'sd0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tpg_load, r_tpg_en, r_misr_clear, r_misr_en;
    logic             r_test_mode, r_bistdone, r_bistpass;
    logic             w_tpg_load, w_tpg_en, w_misr_clear, w_misr_en;
    logic             w_test_mode, w_bistdone, w_bistpass;
    logic             w_sig_match;
    logic [SIG_W-1:0] r_sig_snap;
    logic [SIG_W-1:0] w_sig_snap;

    assign w_sig_match = (bus.misr_sig == GOLDEN_SIG);

    // Next-state and pattern/flush counter; a dropped bistmode aborts from any active state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = bus.bistmode ? S_SEED : S_IDLE;
            end
            S_SEED: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = bus.bistmode ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!bus.bistmode) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == PAT_LAST) begin
                    w_state_nxt = LAT_ZERO ? S_COMPARE : S_FLUSH;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_FLUSH: begin
                if (!bus.bistmode) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == LAT_LAST) begin
                    w_state_nxt = S_COMPARE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            S_COMPARE: w_state_nxt = bus.bistmode ? S_DONE : S_IDLE;
            S_DONE:    w_state_nxt = bus.bistmode ? S_DONE : S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Moore outputs decoded from the upcoming state so they can be registered alongside it.
    always_comb begin
        w_tpg_load   = 1'b0;
        w_tpg_en     = 1'b0;
        w_misr_clear = 1'b0;
        w_misr_en    = 1'b0;
        w_test_mode  = 1'b0;
        w_bistdone   = 1'b0;
        w_bistpass   = 1'b0;
        w_sig_snap   = {SIG_W{1'b0}};
        case (w_state_nxt)
            S_SEED: begin
                w_tpg_load   = 1'b1;
                w_misr_clear = 1'b1;
                w_test_mode  = 1'b1;
            end
            S_RUN: begin
                w_tpg_en    = 1'b1;
                w_test_mode = 1'b1;
                w_misr_en   = LAT_ZERO | (w_cnt_nxt >= LAT_C);
            end
            S_FLUSH: begin
                w_misr_en   = 1'b1;
                w_test_mode = 1'b1;
            end
            S_COMPARE: w_test_mode = 1'b1;
            S_DONE: begin
                w_test_mode = 1'b1;
                w_bistdone  = 1'b1;
                // misr_sig is only looked at on the COMPARE -> DONE edge; DONE just holds.
                w_bistpass  = (r_state == S_COMPARE) ? w_sig_match  : r_bistpass;
                w_sig_snap  = (r_state == S_COMPARE) ? bus.misr_sig : r_sig_snap;
            end
            default: w_test_mode = 1'b0;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_tpg_load   <= 1'b0;
            r_tpg_en     <= 1'b0;
            r_misr_clear <= 1'b0;
            r_misr_en    <= 1'b0;
            r_test_mode  <= 1'b0;
            r_bistdone   <= 1'b0;
            r_bistpass   <= 1'b0;
            r_sig_snap   <= {SIG_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tpg_load   <= w_tpg_load;
            r_tpg_en     <= w_tpg_en;
            r_misr_clear <= w_misr_clear;
            r_misr_en    <= w_misr_en;
            r_test_mode  <= w_test_mode;
            r_bistdone   <= w_bistdone;
            r_bistpass   <= w_bistpass;
            r_sig_snap   <= w_sig_snap;
        end
    end

    assign bus.tpg_load   = r_tpg_load;
    assign bus.tpg_en     = r_tpg_en;
    assign bus.misr_clear = r_misr_clear;
    assign bus.misr_en    = r_misr_en;
    assign bus.test_mode  = r_test_mode;
    assign bus.bistdone   = r_bistdone;
    assign bus.bistpass   = r_bistpass;
`ifdef BIST_SIG_EXPORT_EN
    assign bus.sig_snap   = r_sig_snap;
`else
    logic w_snap_unused;
    assign w_snap_unused = ^r_sig_snap;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: two instances (8 patterns/lat 2, 4 patterns/lat 0)
// checked edge-by-edge against a timeline model of a BIST run with random MISR traffic.
module tb_bist_controller;

    localparam int          SIG_W = 49;
    localparam logic [48:0] GOLD  = 49'h1_2345_6789_ABCD;
    localparam int          NA = 8, LA = 2;
    localparam int          NB = 4, LB = 0;

    logic clk;
    logic rst_a, rst_b;
    int   checks;
    int   errors;

    bist_controller_if #(.SIG_W(SIG_W)) if_a ();
    bist_controller_if #(.SIG_W(SIG_W)) if_b ();

    bist_controller #(.NUM_PATTERNS(NA), .CUT_LAT(LA), .SIG_W(SIG_W), .GOLDEN_SIG(GOLD))
        dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    bist_controller #(.NUM_PATTERNS(NB), .CUT_LAT(LB), .SIG_W(SIG_W), .GOLDEN_SIG(GOLD))
        dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

    always #5 clk = ~clk;

    function automatic logic [48:0] rnd_sig();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[48:0];
    endfunction

    // Expected {tpg_load,tpg_en,misr_clear,misr_en,test_mode,bistdone,bistpass} after edge k of a run.
    function automatic logic [6:0] exp_vec(input int k, input int n, input int l, input logic pass);
        logic [6:0] v;
        v = 7'b0000000;
        if (k == 1) begin
            v = 7'b1010100;
        end else if (k <= n + 1) begin
            v[5] = 1'b1;
            v[2] = 1'b1;
            v[3] = ((k - 2) >= l);
        end else if (k <= n + l + 1) begin
            v[3] = 1'b1;
            v[2] = 1'b1;
        end else if (k == n + l + 2) begin
            v[2] = 1'b1;
        end else begin
            v[2] = 1'b1;
            v[1] = 1'b1;
            v[0] = pass;
        end
        return v;
    endfunction

    task automatic set_mode(input bit sel, input logic v);
        if (sel) if_b.bistmode = v; else if_a.bistmode = v;
    endtask

    task automatic set_sig(input bit sel, input logic [48:0] v);
        if (sel) if_b.misr_sig = v; else if_a.misr_sig = v;
    endtask

    task automatic get_out(input bit sel, output logic [6:0] o, output logic [48:0] s);
        if (sel) o = {if_b.tpg_load, if_b.tpg_en, if_b.misr_clear, if_b.misr_en,
                      if_b.test_mode, if_b.bistdone, if_b.bistpass};
        else     o = {if_a.tpg_load, if_a.tpg_en, if_a.misr_clear, if_a.misr_en,
                      if_a.test_mode, if_a.bistdone, if_a.bistpass};
`ifdef BIST_SIG_EXPORT_EN
        s = sel ? if_b.sig_snap : if_a.sig_snap;
`else
        s = 49'd0;
`endif
    endtask

    // Full run with bistmode held high, then released; sig is presented during COMPARE only.
    task automatic run_check(input bit sel, input int n, input int l, input logic [48:0] sig);
        logic [6:0]  o, e;
        logic [48:0] s, es;
        logic        pass;
        int          ntpg, nmisr, done_edge;
        pass = (sig == GOLD);
        ntpg = 0; nmisr = 0; done_edge = -1;
        set_mode(sel, 1'b1);
        set_sig(sel, rnd_sig());
        for (int k = 1; k <= n + l + 6; k++) begin
            @(posedge clk); #1;
            get_out(sel, o, s);
            e = exp_vec(k, n, l, pass);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_outputs dut=%0d edge=%0d got=%b exp=%b", sel, k, o, e);
            end
            if (o[5] === 1'b1) ntpg++;
            if (o[3] === 1'b1) nmisr++;
            if (o[1] === 1'b1 && done_edge < 0) done_edge = k;
`ifdef BIST_SIG_EXPORT_EN
            es = (k >= n + l + 3) ? sig : 49'd0;
            checks++;
            if (s !== es) begin
                errors++;
                $display("FAIL sig_snap dut=%0d edge=%0d got=%h exp=%h", sel, k, s, es);
            end
`else
            es = 49'd0;
`endif
            set_sig(sel, (k == n + l + 2) ? sig : rnd_sig());
        end
        checks += 3;
        if (ntpg != n) begin
            errors++;
            $display("FAIL tpg_en_total dut=%0d got=%0d exp=%0d", sel, ntpg, n);
        end
        if (nmisr != n) begin
            errors++;
            $display("FAIL misr_en_total dut=%0d got=%0d exp=%0d", sel, nmisr, n);
        end
        if (done_edge != n + l + 3) begin
            errors++;
            $display("FAIL done_latency dut=%0d got=%0d exp=%0d", sel, done_edge, n + l + 3);
        end
        set_mode(sel, 1'b0);
        @(posedge clk); #1;
        get_out(sel, o, s);
        checks++;
        if (o !== 7'b0000000 || s !== 49'd0) begin
            errors++;
            $display("FAIL release_idle dut=%0d got=%b/%h exp=0000000/0", sel, o, s);
        end
    endtask

    task automatic test_reset();
        logic [6:0]  o;
        logic [48:0] s;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            get_out(d[0], o, s);
            checks++;
            if (o !== 7'b0000000 || s !== 49'd0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%b/%h exp=0000000/0", d, o, s);
            end
        end
    endtask

    task automatic test_fault_free();
        set_mode(1'b0, 1'b1);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;
        run_check(1'b0, NA, LA, GOLD);
    endtask

    task automatic test_miscompare();
        run_check(1'b0, NA, LA, GOLD ^ 49'd1);
    endtask

    task automatic test_no_flush();
        run_check(1'b1, NB, LB, GOLD);
        run_check(1'b1, NB, LB, GOLD ^ 49'h1_0000_0000_0000);
    endtask

    task automatic abort_at(input bit sel, input int n, input int l, input int a);
        logic [6:0]  o, e;
        logic [48:0] s;
        set_mode(sel, 1'b1);
        for (int k = 1; k <= a; k++) begin
            @(posedge clk); #1;
            get_out(sel, o, s);
            e = exp_vec(k, n, l, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_pre dut=%0d edge=%0d got=%b exp=%b", sel, k, o, e);
            end
            set_sig(sel, $urandom_range(1, 0) != 0 ? GOLD : rnd_sig());
        end
        set_mode(sel, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            get_out(sel, o, s);
            checks++;
            if (o !== 7'b0000000 || s !== 49'd0) begin
                errors++;
                $display("FAIL abort_idle dut=%0d abort_edge=%0d got=%b exp=0000000", sel, a, o);
            end
        end
        run_check(sel, n, l, GOLD);
    endtask

    task automatic test_abort();
        abort_at(1'b0, NA, LA, 4);
        abort_at(1'b0, NA, LA, NA + LA + 2);
        for (int i = 0; i < 4; i++) begin
            abort_at(1'b0, NA, LA, $urandom_range(NA + LA + 2, 1));
            abort_at(1'b1, NB, LB, $urandom_range(NB + LB + 2, 1));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [6:0]  o, e;
        logic [48:0] s;
        set_mode(1'b0, 1'b1);
        for (int k = 1; k <= NA + 2; k++) begin
            @(posedge clk); #1;
            get_out(1'b0, o, s);
            e = exp_vec(k, NA, LA, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_reset edge=%0d got=%b exp=%b", k, o, e);
            end
        end
        #3;
        rst_a = 1'b0;
        #1;
        get_out(1'b0, o, s);
        checks++;
        if (o !== 7'b0000000 || s !== 49'd0) begin
            errors++;
            $display("FAIL async_reset got=%b/%h exp=0000000/0", o, s);
        end
        @(posedge clk); #1;
        get_out(1'b0, o, s);
        checks++;
        if (o !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=0000000", o);
        end
        rst_a = 1'b1;
        run_check(1'b0, NA, LA, GOLD);
    endtask

    task automatic test_back_to_back();
        run_check(1'b0, NA, LA, GOLD);
        run_check(1'b0, NA, LA, rnd_sig());
        run_check(1'b0, NA, LA, GOLD);
        for (int i = 0; i < 4; i++) begin
            run_check(1'b0, NA, LA, $urandom_range(1, 0) != 0 ? GOLD : rnd_sig());
            run_check(1'b1, NB, LB, $urandom_range(1, 0) != 0 ? GOLD : rnd_sig());
        end
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        if_a.bistmode = 1'b0; if_a.misr_sig = 49'd0;
        if_b.bistmode = 1'b0; if_b.misr_sig = 49'd0;
        test_reset();
        test_fault_free();
        test_miscompare();
        test_no_flush();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
